invpin_piso: RTL

- Sequential parallel-in/serial-out primitive model whose input pins carry `invertible_pin` attributes and matching `INV_*` parameters.
- It is the consumer side of the inverter-integration flow. A netlist in which `$_NOT_` cells were absorbed into `INV_*` parameters must simulate identically to the original netlist with the inverters in place.
- Used as a synthesizable cell model in plugin tests and equivalence benches.

---
 rtl/invpin_piso.sv | 94 +++++++++
 1 files changed

// File: rtl/invpin_piso.sv
// Parallel-in/serial-out cell model whose input pins carry per-pin inversion parameters (INV_*).
// Optional macro INVPIN_PISO_INV_Q_EN adds an INV_Q parameter that inverts the registered Q output.
module invpin_piso #(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] INV_D    = '0,
    parameter logic             INV_LOAD = 1'b0,
    parameter logic             INV_CE   = 1'b0,
    parameter logic             INV_SI   = 1'b0
`ifdef INVPIN_PISO_INV_Q_EN
    ,
    parameter logic             INV_Q    = 1'b0
`endif
) (
    input  logic                                        clk,
    input  logic                                        rst,
    (* invertible_pin = "INV_D" *)    input  logic [WIDTH-1:0] D,
    (* invertible_pin = "INV_LOAD" *) input  logic             LOAD,
    (* invertible_pin = "INV_CE" *)   input  logic             CE,
    (* invertible_pin = "INV_SI" *)   input  logic             SI,
    output logic                                        READY,
`ifdef INVPIN_PISO_INV_Q_EN
    (* invertible_pin = "INV_Q" *)    output logic             Q,
`else
    output logic                                        Q,
`endif
    output logic                                        LAST
);

    localparam int unsigned CNT_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

`ifdef INVPIN_PISO_INV_Q_EN
    localparam logic Q_POL = INV_Q;
`else
    localparam logic Q_POL = 1'b0;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;

    // Absorbed inverters: every decision below uses only these effective values.
    logic [WIDTH-1:0]   d_e;
    logic               ld_e;
    logic               ce_e;
    logic               si_e;

    assign d_e  = D ^ INV_D;
    assign ld_e = LOAD ^ INV_LOAD;
    assign ce_e = CE ^ INV_CE;
    assign si_e = SI ^ INV_SI;

    // READY is a pure state decode so it rises as soon as reset forces IDLE.
    assign READY = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            Q     <= Q_POL;
            LAST  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_e) begin
                        shreg <= d_e;
                        cnt   <= CNT_W'(WIDTH - 1);
                        LAST  <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ce_e) begin
                        Q     <= shreg[0] ^ Q_POL;
                        shreg <= {si_e, shreg[WIDTH-1:1]};
                        LAST  <= (cnt == '0);
                        if (cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
